frame_dark_inv: RTL and testbench

Per-frame adaptive colour-inversion stage for the HDMI pixel path, between the DVI receiver output and the DVI transmitter input in the pixel-clock domain. It generalises the fixed switch-driven XOR inversion to a parametrised channel count and width, with a per-channel mask and four modes. The auto modes count bright pixels each frame and decide, with hysteresis, whether the following frame is inverted. Video timing signals are delayed to stay aligned with the 2-cycle data pipeline.

---
 rtl/frame_dark_inv.sv | 145 ++++++++++++++
 tb/tb_frame_dark_inv.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_dark_inv.sv
// Per-frame adaptive colour inversion for the pixel path.
// Bright-pixel statistics from each frame decide, with hysteresis, whether the next frame is inverted.
module frame_dark_inv #(
   parameter int unsigned CH      = 3,
   parameter int unsigned DW      = 8,
   parameter int unsigned CNT_W   = 22,
   parameter int unsigned PIX_THR = 384,
   parameter int unsigned ON_NUM  = 5,
   parameter int unsigned OFF_NUM = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [1:0]       mode_i,
   input  logic [CH-1:0]    mask_i,
   input  logic             vs_i,
   input  logic             hs_i,
   input  logic             de_i,
   input  logic [CH*DW-1:0] data_i,
   output logic             vs_o,
   output logic             hs_o,
   output logic             de_o,
   output logic [CH*DW-1:0] data_o,
   output logic             inv_o,
   output logic             frame_o
);

   localparam int unsigned PW    = CH * DW;
   localparam int unsigned LW    = DW + 2;
   localparam int unsigned DEC_W = CNT_W + 4;

   logic             vs_d;
   logic [CNT_W-1:0] total_cnt;
   logic [CNT_W-1:0] bright_cnt;
   logic             inv_state;

   logic [PW-1:0]    data_s1;
   logic             vs_s1;
   logic             hs_s1;
   logic             de_s1;
   logic [CH-1:0]    inv_mask_s1;

   logic [LW-1:0]    luma_c;
   logic             bright_c;
   logic             frame_end_c;
   logic             eff_c;
   logic [DEC_W-1:0] bright_x8_c;
   logic [DEC_W-1:0] on_lim_c;
   logic [DEC_W-1:0] off_lim_c;
   logic [PW-1:0]    inv_bits_c;

   // Pixel luma and frame-end detection
   always_comb begin
      luma_c = '0;
      for (int unsigned c = 0; c < CH; c++) begin
         luma_c = luma_c + LW'(data_i[c*DW +: DW]);
      end
      bright_c    = (luma_c >= LW'(PIX_THR));
      frame_end_c = vs_i & ~vs_d;
   end

   // Fraction thresholds scaled by 8 so no division is needed
   always_comb begin
      bright_x8_c = DEC_W'({bright_cnt, 3'b000});
      on_lim_c    = DEC_W'(total_cnt) * DEC_W'(ON_NUM);
      off_lim_c   = DEC_W'(total_cnt) * DEC_W'(OFF_NUM);
   end

   always_comb begin
      eff_c = 1'b0;
      case (mode_i)
         2'b00:   eff_c = 1'b0;
         2'b01:   eff_c = 1'b1;
         2'b10:   eff_c = inv_state;
         default: eff_c = ~inv_state;
      endcase
   end

   always_comb begin
      inv_bits_c = '0;
      for (int unsigned c = 0; c < CH; c++) begin
         inv_bits_c[c*DW +: DW] = {DW{inv_mask_s1[c]}};
      end
   end

   // Frame statistics and hysteresis decision.
   // vs_d keeps tracking vs_i during reset so a vs held high through reset is not seen as an edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vs_d       <= vs_i;
         total_cnt  <= '0;
         bright_cnt <= '0;
         inv_state  <= 1'b0;
         frame_o    <= 1'b0;
      end else begin
         vs_d    <= vs_i;
         frame_o <= frame_end_c;
         if (frame_end_c) begin
            total_cnt  <= CNT_W'(de_i);
            bright_cnt <= CNT_W'(de_i & bright_c);
            if (total_cnt != '0) begin
               if (!inv_state && (bright_x8_c >= on_lim_c)) begin
                  inv_state <= 1'b1;
               end else if (inv_state && (bright_x8_c < off_lim_c)) begin
                  inv_state <= 1'b0;
               end
            end
         end else begin
            if (de_i && (total_cnt != '1)) begin
               total_cnt <= total_cnt + CNT_W'(1);
            end
            if (de_i && bright_c && (bright_cnt != '1)) begin
               bright_cnt <= bright_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign inv_o = inv_state;

   // Two-stage data/sync pipeline
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_s1     <= '0;
         vs_s1       <= 1'b0;
         hs_s1       <= 1'b0;
         de_s1       <= 1'b0;
         inv_mask_s1 <= '0;
         data_o      <= '0;
         vs_o        <= 1'b0;
         hs_o        <= 1'b0;
         de_o        <= 1'b0;
      end else begin
         data_s1     <= data_i;
         vs_s1       <= vs_i;
         hs_s1       <= hs_i;
         de_s1       <= de_i;
         inv_mask_s1 <= {CH{eff_c}} & mask_i;
         data_o      <= data_s1 ^ inv_bits_c;
         vs_o        <= vs_s1;
         hs_o        <= hs_s1;
         de_o        <= de_s1;
      end
   end

endmodule

// File: tb/tb_frame_dark_inv.sv
// Bench for frame_dark_inv: random stimulus checked against a frame-level reference model.
module tb_frame_dark_inv;

   localparam int CH  = 3;
   localparam int DW  = 8;
   localparam int W   = CH * DW;
   localparam int THR = 384;
   localparam int ON  = 5;
   localparam int OFF = 3;
   localparam logic [W-1:0] WHITE = 24'hFFFFFF;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    mode;
   logic [CH-1:0] mask;
   logic          vs, hs, de;
   logic [W-1:0]  data;
   logic          vs_o, hs_o, de_o, inv_o, frame_o;
   logic [W-1:0]  data_o;

   int errors = 0;
   int checks = 0;

   // Reference model state
   int             m_total, m_bright;
   bit             m_inv, m_vsd, m_frame;
   logic [W+2:0]   m_pipe1, m_out;

   always #5 clk = ~clk;

   frame_dark_inv dut (
      .clk_i(clk), .rst_i(rst), .mode_i(mode), .mask_i(mask),
      .vs_i(vs), .hs_i(hs), .de_i(de), .data_i(data),
      .vs_o(vs_o), .hs_o(hs_o), .de_o(de_o), .data_o(data_o),
      .inv_o(inv_o), .frame_o(frame_o)
   );

   // One clock of stimulus; the model predicts what the outputs show just after this edge.
   task automatic tick(input bit r, input bit v, input bit h, input bit d, input logic [W-1:0] px);
      bit eff, fe;
      int s;
      logic [W-1:0] inv_bits;
      @(negedge clk);
      rst = r; vs = v; hs = h; de = d; data = px;
      if (r) begin
         m_out = '0; m_pipe1 = '0; m_inv = 0; m_total = 0; m_bright = 0;
         m_frame = 0; m_vsd = v;
      end else begin
         case (mode)
            2'd0: eff = 0;
            2'd1: eff = 1;
            2'd2: eff = m_inv;
            default: eff = !m_inv;
         endcase
         inv_bits = '0;
         s = 0;
         for (int c = 0; c < CH; c++) begin
            if (eff && mask[c]) inv_bits[c*DW +: DW] = '1;
            s += int'(px[c*DW +: DW]);
         end
         m_out   = m_pipe1;
         m_pipe1 = {v, h, d, px ^ inv_bits};
         fe      = v && !m_vsd;
         m_vsd   = v;
         m_frame = fe;
         if (fe) begin
            if (m_total > 0) begin
               if (!m_inv && 8 * m_bright >= ON * m_total) m_inv = 1;
               else if (m_inv && 8 * m_bright < OFF * m_total) m_inv = 0;
            end
            m_total  = d ? 1 : 0;
            m_bright = (d && s >= THR) ? 1 : 0;
         end else begin
            m_total  += d ? 1 : 0;
            m_bright += (d && s >= THR) ? 1 : 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         mode = 2'($urandom); mask = 3'($urandom);
         tick(1, 1'($urandom), 1'($urandom), 1'($urandom), 24'($urandom));
         checks++;
         if ({vs_o, hs_o, de_o, data_o, inv_o, frame_o} !== '0) begin
            errors++;
            $display("FAIL reset: outputs=%h required 0", {vs_o, hs_o, de_o, data_o, inv_o, frame_o});
         end
      end
      tick(1, 0, 0, 0, '0);
   endtask

   task automatic test_pass();
      logic [W-1:0] px;
      mode = 2'd0; mask = 3'($urandom);
      for (int i = 0; i < 12; i++) begin
         px = (i == 5) ? 24'h123456 : 24'($urandom);
         tick(0, 0, 1'($urandom), (i == 5) ? 1'b1 : 1'($urandom), px);
         checks++;
         if ({vs_o, hs_o, de_o, data_o, inv_o, frame_o} !== {m_out, m_inv, m_frame}) begin
            errors++;
            $display("FAIL pass cyc%0d: got %h required %h", i,
                     {vs_o, hs_o, de_o, data_o, inv_o, frame_o}, {m_out, m_inv, m_frame});
         end
         if (i == 6) begin
            checks++;
            if (data_o !== 24'h123456 || de_o !== 1'b1) begin
               errors++;
               $display("FAIL pass_lit: data_o=%h de_o=%b required 123456 1", data_o, de_o);
            end
         end
      end
   endtask

   task automatic test_force();
      mode = 2'd1; mask = 3'b101;
      tick(0, 0, 0, 1, 24'h00FF10);
      mask = 3'b010;
      tick(0, 0, 0, 1, 24'h00FF10);
      checks++;
      if (data_o !== 24'hFFFFEF) begin
         errors++;
         $display("FAIL force_101: data_o=%h required FFFFEF", data_o);
      end
      tick(0, 0, 1'($urandom), 1'($urandom), 24'($urandom));
      checks++;
      if (data_o !== 24'h000010) begin
         errors++;
         $display("FAIL force_010: data_o=%h required 000010", data_o);
      end
      for (int i = 0; i < 10; i++) begin
         mask = 3'($urandom);
         tick(0, 0, 1'($urandom), 1'($urandom), 24'($urandom));
         checks++;
         if ({vs_o, hs_o, de_o, data_o, inv_o, frame_o} !== {m_out, m_inv, m_frame}) begin
            errors++;
            $display("FAIL force cyc%0d: got %h required %h", i,
                     {vs_o, hs_o, de_o, data_o, inv_o, frame_o}, {m_out, m_inv, m_frame});
         end
      end
   endtask

   // 100-pixel frame (whites then blacks), then a vs pulse; every cycle checked against the model.
   task automatic run_frame(input string name, input int nw, output logic [W-1:0] first_out,
                            output bit edge_inv, output bit edge_frame);
      for (int i = 0; i < 104; i++) begin
         if (i < 100)       tick(0, 0, 1'($urandom), 1, (i < nw) ? WHITE : '0);
         else if (i < 102)  tick(0, 1, 0, 0, 24'($urandom));
         else               tick(0, 0, 0, 0, 24'($urandom));
         if (i == 1)   first_out = data_o;
         if (i == 100) begin edge_inv = inv_o; edge_frame = frame_o; end
         checks++;
         if ({vs_o, hs_o, de_o, data_o, inv_o, frame_o} !== {m_out, m_inv, m_frame}) begin
            errors++;
            $display("FAIL %s cyc%0d: got %h required %h", name, i,
                     {vs_o, hs_o, de_o, data_o, inv_o, frame_o}, {m_out, m_inv, m_frame});
         end
      end
   endtask

   task automatic test_auto();
      logic [W-1:0] fo;
      bit ei, ef;
      mode = 2'd2; mask = 3'b111;
      tick(1, 0, 0, 0, '0);
      run_frame("auto_w100", 100, fo, ei, ef);
      checks++;
      if (ei !== 1'b1 || ef !== 1'b1) begin
         errors++;
         $display("FAIL auto_edge1: inv=%b frame=%b required 1 1", ei, ef);
      end
      run_frame("auto_w50", 50, fo, ei, ef);
      checks++;
      if (fo !== 24'h000000 || ei !== 1'b1) begin
         errors++;
         $display("FAIL auto_w50: first=%h inv=%b required 000000 1", fo, ei);
      end
      run_frame("auto_w30", 30, fo, ei, ef);
      checks++;
      if (ei !== 1'b0) begin
         errors++;
         $display("FAIL auto_w30: inv=%b required 0", ei);
      end
      mode = 2'd3;
      tick(1, 0, 0, 0, '0);
      run_frame("autoinv_w100", 100, fo, ei, ef);
      checks++;
      if (fo !== 24'h000000 || ei !== 1'b1) begin
         errors++;
         $display("FAIL autoinv_w100: first=%h inv=%b required 000000 1", fo, ei);
      end
      run_frame("autoinv_w50", 50, fo, ei, ef);
      checks++;
      if (fo !== WHITE) begin
         errors++;
         $display("FAIL autoinv_w50: first=%h required FFFFFF", fo);
      end
   endtask

   task automatic test_empty();
      logic [W-1:0] fo;
      bit ei, ef;
      mode = 2'd2; mask = 3'b111;
      tick(1, 0, 0, 0, '0);
      run_frame("empty_pre", 100, fo, ei, ef);
      for (int i = 0; i < 3; i++) tick(0, 0, 1'($urandom), 0, 24'($urandom));
      tick(0, 1, 0, 0, '0);
      checks++;
      if (inv_o !== 1'b1 || frame_o !== 1'b1) begin
         errors++;
         $display("FAIL empty_frame: inv=%b frame=%b required 1 1", inv_o, frame_o);
      end
      tick(0, 0, 0, 0, '0);
      tick(0, 1, 0, 1, '0);    // dark pixel on the vs edge belongs to the new frame
      tick(0, 0, 0, 0, '0);
      tick(0, 1, 0, 0, '0);
      checks++;
      if (inv_o !== 1'b0 || inv_o !== m_inv) begin
         errors++;
         $display("FAIL edge_pixel: inv=%b required 0", inv_o);
      end
   endtask

   task automatic test_reset_mid();
      mode = 2'd2; mask = 3'b111;
      tick(1, 0, 0, 0, '0);
      for (int i = 0; i < 80; i++) tick(0, 0, 0, 1, WHITE);
      tick(1, 0, 0, 0, '0);
      for (int i = 0; i < 10; i++) tick(0, 0, 0, 1, '0);
      tick(0, 1, 0, 0, '0);
      checks++;
      if (inv_o !== 1'b0 || frame_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid: inv=%b frame=%b required 0 1", inv_o, frame_o);
      end
      tick(1, 1, 0, 0, '0);
      tick(0, 1, 0, 0, '0);
      checks++;
      if (frame_o !== 1'b0) begin
         errors++;
         $display("FAIL vs_high_reset: frame=%b required 0", frame_o);
      end
      tick(0, 0, 0, 0, '0);
      tick(0, 1, 0, 0, '0);
      checks++;
      if (frame_o !== 1'b1) begin
         errors++;
         $display("FAIL vs_rise_after: frame=%b required 1", frame_o);
      end
   endtask

   task automatic test_random();
      int len;
      logic [W-1:0] px;
      tick(1, 0, 0, 0, '0);
      for (int f = 0; f < 24; f++) begin
         mode = 2'($urandom);
         mask = 3'($urandom);
         len  = int'($urandom_range(0, 60));
         for (int i = 0; i < len + 3; i++) begin
            case ($urandom_range(0, 2))
               0: px = WHITE;
               1: px = '0;
               default: px = 24'($urandom);
            endcase
            if ($urandom_range(0, 40) == 0) mask = 3'($urandom);
            tick(0, (i == len) || (i == len + 1), 1'($urandom), 1'($urandom), px);
            checks++;
            if ({vs_o, hs_o, de_o, data_o, inv_o, frame_o} !== {m_out, m_inv, m_frame}) begin
               errors++;
               $display("FAIL random f%0d cyc%0d: got %h required %h", f, i,
                        {vs_o, hs_o, de_o, data_o, inv_o, frame_o}, {m_out, m_inv, m_frame});
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; mode = '0; mask = '0; vs = 0; hs = 0; de = 0; data = '0;
      m_total = 0; m_bright = 0; m_inv = 0; m_vsd = 0; m_frame = 0;
      m_pipe1 = '0; m_out = '0;
      test_reset();
      test_pass();
      test_force();
      test_auto();
      test_empty();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
